f_div: RTL
==========

F_DIV -- requirements
Module: f_div

Interface
REQ-001 Parameters: none; fixed IEEE-754 binary32 format.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operands and rounding mode valid this cycle.
REQ-005 in_ready  output  1  high only in IDLE; a transfer occurs on an edge with in_valid and in_ready both high.
REQ-006 a  input  32  dividend, binary32.
REQ-007 b  input  32  divisor, binary32.
REQ-008 rounding  input  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; codes 101-111 are treated as RNE.
REQ-009 y  output  32  quotient a/b, registered; holds its value until the next result.
REQ-010 flags  output  5  [4]NV [3]DZ [2]OF [1]UF [0]NX, registered alongside y.
REQ-011 out_valid  output  1  one-cycle pulse marking new y/flags.

Function
REQ-012 The FSM has three states, IDLE, DIV and ROUND, with transitions IDLE->DIV on transfer (normal operands), DIV->ROUND after 27 iterations, ROUND->IDLE, and IDLE->IDLE on transfer (special operands).
REQ-013 Operands and rounding SHALL be captured on the transfer edge; a and b changes after that edge have no effect.
REQ-014 in_valid outside IDLE SHALL be ignored, with no capture and no state change.
REQ-015 Subnormal inputs SHALL be treated as signed zero (DAZ), and output sign = a[31]^b[31] except for NaN.
REQ-016 Special cases resolve in 1 cycle: y/flags/out_valid are registered on the edge following the transfer edge.
- either NaN -> 0x7FC00000; NV if either is sNaN.
- 0/0 or inf/inf -> 0x7FC00000, NV.
- finite nonzero / 0 -> signed inf, DZ.
- inf / finite -> signed inf, no flags.
- 0 / nonzero-finite, or finite / inf -> signed zero, no flags.
REQ-017 Normal path, mantissas ma={1,a[22:0]} and mb={1,b[22:0]}: the remainder is initialised to ma, then for each of 27 DIV cycles the datapath performs: if rem>=mb then q bit=1 and rem-=mb; then rem<<=1, with q shifted in MSB-first into q[26:0].
REQ-018 Exponent: e = ea - eb + 127 in 10-bit signed; if q[26]=0, e-=1.
REQ-019 Mantissa selection:
- q[26]=1: sig=q[26:3], round bit=q[2], sticky=|q[1:0] | (rem!=0).
- q[26]=0: sig=q[25:2], round bit=q[1], sticky=q[0] | (rem!=0).
REQ-020 NX = round|sticky; the increment decision follows the captured mode; a rounding carry out of sig SHALL set sig=1.0 and e+=1.
REQ-021 After rounding, overflow (e>=255) SHALL set OF|NX, with result inf for RNE/RMM, for RUP on positive and for RDN on negative; otherwise the result is 0x7F7FFFFF with the sign applied.
REQ-022 After rounding, underflow (e<=0) SHALL flush to signed zero and set UF|NX.
REQ-023 Latency, counting the transfer edge as edge 0: DIV iterations occur at edges 1..27, and edge 28 registers y/flags with out_valid=1; out_valid=0 at edge 29.
REQ-024 The FSM returns to IDLE at the same edge that raises out_valid, so in_ready=1 during the out_valid cycle and a back-to-back transfer is allowed.
REQ-025 flags SHALL be replaced, not accumulated, per result.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, y=0x00000000, flags=0, iteration counter=0, regardless of the clock.
REQ-027 Reset mid-operation SHALL abandon the operation, with no out_valid pulse for it.
REQ-028 The first transfer is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-029 a=0x40C00000, b=0x40000000, RNE -> y=0x40400000, flags=0, out_valid only at edge 28.
REQ-030 a=0x3F800000, b=0x40400000: RNE -> 0x3EAAAAAB with NX; RTZ -> 0x3EAAAAAA with NX.
REQ-031 a=0x3F800000, b=0x00000000 -> 0x7F800000, DZ, out_valid at edge 1; 0/0 -> 0x7FC00000, NV.
REQ-032 a=0x7F7FFFFF, b=0x3F000000: RNE -> 0x7F800000 with OF|NX; RTZ -> 0x7F7FFFFF with OF|NX.
REQ-033 rst_n pulsed low at edge 10 of an operation -> no out_valid, y=0, in_ready=1; the next 6.0/2.0 completes correctly.
REQ-034 in_valid held high with new operands during DIV -> ignored; the result is that of the first operands, and the second operands are accepted in the out_valid cycle.

Source files
------------

// File: rtl/f_div.sv
// f_div: IEEE-754 binary32 divider using a restoring iterative datapath.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake; in_ready is high only in IDLE
//   a, b                dividend and divisor (binary32)
//   rounding            000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   y, flags            registered quotient and {NV,DZ,OF,UF,NX}
//   out_valid           one-cycle pulse marking a new y/flags
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for operands; special-operand results resolve from here
// DIV    | one quotient bit per cycle, 27 cycles
// ROUND  | normalise, round, register y/flags, return to IDLE
//
// Subnormal inputs are treated as signed zero.

module f_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rounding,
    output logic [31:0] y,
    output logic [4:0]  flags,
    output logic        out_valid
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [24:0] rem;
    logic [26:0] q;
    logic [23:0] mb;
    logic [7:0]  ea, eb;
    logic        sgn;
    logic [2:0]  rm;
    logic        spec_pend;
    logic [31:0] spec_y;
    logic [4:0]  spec_flags;

    logic        take;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic        in_sign;
    logic        is_special;
    logic [31:0] sp_y;
    logic [4:0]  sp_flags;

    logic        ge;
    logic [24:0] rem_d;

    logic [9:0]  e_pre, e_fin;
    logic [23:0] sig;
    logic        rbit, sbit, inc, nx, to_inf, carry;
    logic [24:0] sig_inc;
    logic [22:0] mant;
    logic [31:0] res_y;
    logic [4:0]  res_flags;

    assign in_ready = (state == S_IDLE);
    assign take     = in_valid && in_ready;

    // Operand classification (exponent 0 means zero: denormals flushed)
    assign a_zero  = (a[30:23] == 8'd0);
    assign b_zero  = (b[30:23] == 8'd0);
    assign a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign a_snan  = a_nan && !a[22];
    assign b_snan  = b_nan && !b[22];
    assign in_sign = a[31] ^ b[31];

    // inf/0 is caught by the a_inf branch before the divide-by-zero branch
    always_comb begin
        sp_y       = 32'd0;
        sp_flags   = 5'd0;
        is_special = 1'b1;
        if (a_nan || b_nan) begin
            sp_y     = QNAN;
            sp_flags = {(a_snan || b_snan), 4'b0000};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_y     = QNAN;
            sp_flags = 5'b10000;
        end else if (a_inf) begin
            sp_y = {in_sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            sp_y     = {in_sign, 8'hFF, 23'd0};
            sp_flags = 5'b01000;
        end else if (a_zero || b_inf) begin
            sp_y = {in_sign, 31'd0};
        end else begin
            is_special = 1'b0;
        end
    end

    // One restoring step
    always_comb begin
        ge    = (rem >= {1'b0, mb});
        rem_d = ge ? (rem - {1'b0, mb}) : rem;
    end

    // Normalise and round the finished quotient
    always_comb begin
        e_pre = {2'b00, ea} - {2'b00, eb} + 10'd127;
        if (q[26]) begin
            sig  = q[26:3];
            rbit = q[2];
            sbit = (|q[1:0]) | (|rem);
        end else begin
            sig   = q[25:2];
            rbit  = q[1];
            sbit  = q[0] | (|rem);
            e_pre = e_pre - 10'd1;
        end

        case (rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sgn & (rbit | sbit);
            3'b011:  inc = ~sgn & (rbit | sbit);
            3'b100:  inc = rbit;
            default: inc = rbit & (sbit | sig[0]);
        endcase

        case (rm)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = sgn;
            3'b011:  to_inf = ~sgn;
            default: to_inf = 1'b1;
        endcase

        sig_inc = {1'b0, sig} + {24'd0, inc};
        // Carry out of the 24-bit significand leaves exactly 1.0 x 2
        carry   = (sig_inc[24:23] == 2'b10);
        e_fin   = e_pre + {9'd0, carry};
        mant    = carry ? 23'd0 : sig_inc[22:0];
        nx      = rbit | sbit;

        res_y     = {sgn, e_fin[7:0], mant};
        res_flags = {4'b0000, nx};
        if ($signed(e_fin) >= 10'sd255) begin
            res_y     = to_inf ? {sgn, 8'hFF, 23'd0} : {sgn, 31'h7F7F_FFFF};
            res_flags = 5'b00101;
        end else if ($signed(e_fin) <= 10'sd0) begin
            res_y     = {sgn, 31'd0};
            res_flags = 5'b00011;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (take && !is_special) state_nxt = S_DIV;
            S_DIV:   if (cnt == 5'd0) state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 5'd0;
            rem        <= 25'd0;
            q          <= 27'd0;
            mb         <= 24'd0;
            ea         <= 8'd0;
            eb         <= 8'd0;
            sgn        <= 1'b0;
            rm         <= 3'd0;
            spec_pend  <= 1'b0;
            spec_y     <= 32'd0;
            spec_flags <= 5'd0;
            y          <= 32'd0;
            flags      <= 5'd0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            spec_pend <= 1'b0;

            // Special results take one extra edge so out_valid lands at edge 1
            if (spec_pend) begin
                y         <= spec_y;
                flags     <= spec_flags;
                out_valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (take) begin
                        if (is_special) begin
                            spec_pend  <= 1'b1;
                            spec_y     <= sp_y;
                            spec_flags <= sp_flags;
                        end else begin
                            rem <= {2'b01, a[22:0]};
                            mb  <= {1'b1, b[22:0]};
                            q   <= 27'd0;
                            cnt <= 5'd26;
                            ea  <= a[30:23];
                            eb  <= b[30:23];
                            sgn <= in_sign;
                            rm  <= rounding;
                        end
                    end
                end
                S_DIV: begin
                    rem <= rem_d << 1;
                    q   <= {q[25:0], ge};
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                S_ROUND: begin
                    y         <= res_y;
                    flags     <= res_flags;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
